// File: rtl/edge_cnt_pkg.sv
// -----------------------------------------------------------------------------
// edge_cnt_pkg
// Shared types and helpers for the multi-channel edge counter.
//   edge_mode_t : per-channel edge selection (rise / fall / both / off)
//   clog2_min1  : ceil(log2(n)) but never less than 1, for select widths
// -----------------------------------------------------------------------------
package edge_cnt_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_cnt_channel.sv
// -----------------------------------------------------------------------------
// edge_cnt_channel
// One channel of the edge counter: input synchroniser, previous-value flop,
// mode-selected edge detection, wrap/saturate counter and sticky overflow.
// Optional threshold interrupt when EDGE_CNT_THRESH_IRQ_EN is defined.
//
// Ports
//   clk, rstn : clock, asynchronous active-low reset
//   din       : asynchronous event input
//   mode      : edge selection for this channel
//   clr       : synchronous clear of counter, overflow (and irq)
//   rd_clr    : read-and-clear of this channel (lower priority than clr)
//   thresh    : interrupt threshold, 0 disables   (EDGE_CNT_THRESH_IRQ_EN)
//   irq       : registered threshold interrupt    (EDGE_CNT_THRESH_IRQ_EN)
//   cnt, ovf  : live counter and sticky overflow flag
// -----------------------------------------------------------------------------
module edge_cnt_channel
  import edge_cnt_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  edge_mode_t       mode,
  input  logic             clr,
  input  logic             rd_clr,
`ifdef EDGE_CNT_THRESH_IRQ_EN
  input  logic [WIDTH-1:0] thresh,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_cnt;
  logic                   r_ovf;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_hit;
  logic                   w_at_max;
  logic [WIDTH-1:0]       w_cnt_nxt;
  logic                   w_ovf_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
    end
  end

  // prev resets to 0, so an input held high through reset reads as one rise.
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s & ~r_prev;
  assign w_fall   = ~w_s & r_prev;
  assign w_at_max = (r_cnt == CNT_MAX);

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_hit = 1'b0;
    unique case (mode)
      EDGE_RISE: w_hit = w_rise;
      EDGE_FALL: w_hit = w_fall;
      EDGE_BOTH: w_hit = w_rise | w_fall;
      EDGE_OFF:  w_hit = 1'b0;
      default:   w_hit = 1'b0;
    endcase
  end

  // Priority: clr > read-clear > increment. A read that coincides with a
  // counted edge restarts at 1; overflow is judged against the old count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (clr) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (rd_clr) begin
      w_cnt_nxt = w_hit ? WIDTH'(1) : '0;
      w_ovf_nxt = w_hit & w_at_max;
    end else if (w_hit) begin
      if (w_at_max) begin
        w_cnt_nxt = (SATURATE != 0) ? CNT_MAX : '0;
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign cnt = r_cnt;
  assign ovf = r_ovf;

`ifdef EDGE_CNT_THRESH_IRQ_EN
  logic r_irq_pend;
  logic r_irq;
  logic w_irq_set;

  // Fires only when an edge moves the counter onto thresh (a saturated hold
  // at thresh is not a new arrival). irq follows one cycle after the count.
  assign w_irq_set = ~clr & w_hit & (thresh != '0) & (w_cnt_nxt == thresh) &
                     (rd_clr | (w_cnt_nxt != r_cnt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_irq_pend <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_pend <= w_irq_set;
      if (clr || rd_clr) r_irq <= 1'b0;
      else if (r_irq_pend) r_irq <= 1'b1;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: rtl/multi_channel_edge_counter.sv
// -----------------------------------------------------------------------------
// multi_channel_edge_counter
// NCH independent synchronised edge counters with a registered read-and-clear
// port and a flat live-count bus.
// Optional feature macro: EDGE_CNT_THRESH_IRQ_EN (adds thresh input, irq output).
//
// Ports
//   clk, rstn : clock, asynchronous active-low reset
//   din       : [NCH] asynchronous event inputs
//   mode      : [2*NCH] per-channel edge_mode_t, ch i at [2i+1:2i]
//   clr       : synchronous clear of all counters and flags
//   rd_en     : read-and-clear strobe
//   rd_sel    : channel to read; out-of-range selects return zero
//   rd_data   : registered pre-clear count of the selected channel
//   rd_ovf    : registered pre-clear overflow flag of the selected channel
//   rd_valid  : high for one cycle after an accepted rd_en
//   cnt_bus   : [NCH*WIDTH] live counters, ch i at [WIDTH*i +: WIDTH]
//   ovf       : [NCH] live sticky overflow flags
//   thresh    : [WIDTH] interrupt threshold (EDGE_CNT_THRESH_IRQ_EN)
//   irq       : [NCH] threshold interrupts   (EDGE_CNT_THRESH_IRQ_EN)
// -----------------------------------------------------------------------------
module multi_channel_edge_counter
  import edge_cnt_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 1,
  localparam int SEL_W      = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH-1:0]       din,
  input  logic [2*NCH-1:0]     mode,
  input  logic                 clr,
  input  logic                 rd_en,
  input  logic [SEL_W-1:0]     rd_sel,
`ifdef EDGE_CNT_THRESH_IRQ_EN
  input  logic [WIDTH-1:0]     thresh,
  output logic [NCH-1:0]       irq,
`endif
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_ovf,
  output logic                 rd_valid,
  output logic [NCH*WIDTH-1:0] cnt_bus,
  output logic [NCH-1:0]       ovf
);

  logic [WIDTH-1:0] w_cnt [NCH];
  logic [NCH-1:0]   w_ovf;
  logic [NCH-1:0]   w_rd_clr;
  logic [WIDTH-1:0] w_rd_cnt;
  logic             w_rd_ovf;

  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_ovf;
  logic             r_rd_valid;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_rd_clr[g] = rd_en & (rd_sel == SEL_W'(g));

    edge_cnt_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .SATURATE    (SATURATE)
    ) u_ch (
      .clk    (clk),
      .rstn   (rstn),
      .din    (din[g]),
      .mode   (edge_mode_t'(mode[2*g +: 2])),
      .clr    (clr),
      .rd_clr (w_rd_clr[g]),
`ifdef EDGE_CNT_THRESH_IRQ_EN
      .thresh (thresh),
      .irq    (irq[g]),
`endif
      .cnt    (w_cnt[g]),
      .ovf    (w_ovf[g])
    );

    assign cnt_bus[WIDTH*g +: WIDTH] = w_cnt[g];
  end

  assign ovf = w_ovf;

  // Selects beyond NCH fall through to zero and match no channel.
  always_comb begin
    w_rd_cnt = '0;
    w_rd_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        w_rd_cnt = w_cnt[i];
        w_rd_ovf = w_ovf[i];
      end
    end
  end

  // Read data captures pre-edge values, so a simultaneous clr or clear of the
  // same channel still returns what was there before.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data  <= '0;
      r_rd_ovf   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_cnt;
        r_rd_ovf  <= w_rd_ovf;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_ovf   = r_rd_ovf;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_multi_channel_edge_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_edge_counter
// Two DUT copies share all inputs: one saturating, one wrapping. A behavioural
// model predicts every output from the din sample history and the counting
// rules; directed steps also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_multi_channel_edge_counter;
  import edge_cnt_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int SS  = 2;
  localparam int MAXV = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NCH-1:0]   din;
  logic [2*NCH-1:0] mode;
  logic             clr;
  logic             rd_en;
  logic [1:0]       rd_sel;

  logic [W-1:0]     rd_data_s, rd_data_w;
  logic             rd_ovf_s, rd_ovf_w, rd_valid_s, rd_valid_w;
  logic [NCH*W-1:0] cnt_bus_s, cnt_bus_w;
  logic [NCH-1:0]   ovf_s, ovf_w;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 = saturating copy, 1 = wrapping copy.
  int             m_cnt [2][NCH];
  bit             m_ovf [2][NCH];
  int             m_rd_data [2];
  bit             m_rd_ovf [2];
  bit             m_rd_valid;
  logic [NCH-1:0] hist [$];   // hist[0] = din sampled at the most recent edge

  always #5 clk = ~clk;

  multi_channel_edge_counter #(.NCH(NCH), .WIDTH(W), .SYNC_STAGES(SS), .SATURATE(1)) dut_s (
    .clk(clk), .rstn(rstn), .din(din), .mode(mode), .clr(clr), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .rd_valid(rd_valid_s),
    .cnt_bus(cnt_bus_s), .ovf(ovf_s)
  );

  multi_channel_edge_counter #(.NCH(NCH), .WIDTH(W), .SYNC_STAGES(SS), .SATURATE(0)) dut_w (
    .clk(clk), .rstn(rstn), .din(din), .mode(mode), .clr(clr), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .rd_valid(rd_valid_w),
    .cnt_bus(cnt_bus_w), .ovf(ovf_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[k][c] = 0;
        m_ovf[k][c] = 1'b0;
      end
      m_rd_data[k] = 0;
      m_rd_ovf[k]  = 1'b0;
    end
    m_rd_valid = 1'b0;
    hist.delete();
    repeat (SS + 1) hist.push_back('0);
  endtask

  // An edge counted at this clock is the change between the din samples taken
  // SS+1 and SS clocks earlier.
  task automatic model_edge(input logic [NCH-1:0] d, input logic [2*NCH-1:0] md,
                            input bit c, input bit re, input int sel);
    logic [NCH-1:0] now_v, old_v;
    bit hit [NCH];
    now_v = hist[SS-1];
    old_v = hist[SS];
    for (int ch = 0; ch < NCH; ch++) begin
      bit r, f;
      r = now_v[ch] && !old_v[ch];
      f = !now_v[ch] && old_v[ch];
      case (md[2*ch +: 2])
        2'b00:   hit[ch] = r;
        2'b01:   hit[ch] = f;
        2'b10:   hit[ch] = r || f;
        default: hit[ch] = 1'b0;
      endcase
    end
    m_rd_valid = re;
    for (int k = 0; k < 2; k++) begin
      if (re) begin
        m_rd_data[k] = (sel < NCH) ? m_cnt[k][sel] : 0;
        m_rd_ovf[k]  = (sel < NCH) ? m_ovf[k][sel] : 1'b0;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (c) begin
          m_cnt[k][ch] = 0;
          m_ovf[k][ch] = 1'b0;
        end else if (re && sel == ch) begin
          m_ovf[k][ch] = hit[ch] && (m_cnt[k][ch] == MAXV);
          m_cnt[k][ch] = hit[ch] ? 1 : 0;
        end else if (hit[ch]) begin
          if (m_cnt[k][ch] + 1 > MAXV) begin
            m_ovf[k][ch] = 1'b1;
            m_cnt[k][ch] = (k == 0) ? MAXV : 0;
          end else begin
            m_cnt[k][ch] = m_cnt[k][ch] + 1;
          end
        end
      end
    end
    hist.push_front(d);
    void'(hist.pop_back());
  endtask

  task automatic check_all();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("sat_cnt%0d", ch), 32'(cnt_bus_s[W*ch +: W]), 32'(m_cnt[0][ch]));
      check($sformatf("wrap_cnt%0d", ch), 32'(cnt_bus_w[W*ch +: W]), 32'(m_cnt[1][ch]));
      check($sformatf("sat_ovf%0d", ch), 32'(ovf_s[ch]), 32'(m_ovf[0][ch]));
      check($sformatf("wrap_ovf%0d", ch), 32'(ovf_w[ch]), 32'(m_ovf[1][ch]));
    end
    check("sat_rd_data", 32'(rd_data_s), 32'(m_rd_data[0]));
    check("wrap_rd_data", 32'(rd_data_w), 32'(m_rd_data[1]));
    check("sat_rd_ovf", 32'(rd_ovf_s), 32'(m_rd_ovf[0]));
    check("wrap_rd_ovf", 32'(rd_ovf_w), 32'(m_rd_ovf[1]));
    check("sat_rd_valid", 32'(rd_valid_s), 32'(m_rd_valid));
    check("wrap_rd_valid", 32'(rd_valid_w), 32'(m_rd_valid));
  endtask

  // Inputs are driven at posedge+1; the tick captures them, lets the edge
  // happen, advances the model and compares everything at posedge+1.
  task automatic tick();
    logic [NCH-1:0]   d;
    logic [2*NCH-1:0] md;
    bit               c, re;
    int               sel;
    d = din; md = mode; c = clr; re = rd_en; sel = int'(rd_sel);
    @(posedge clk);
    model_edge(d, md, c, re, sel);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rstn = 1'b0; din = '0; mode = '0; clr = 1'b0; rd_en = 1'b0; rd_sel = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_cnt_bus", 32'(cnt_bus_s), 32'd0);
    rstn = 1'b1;

    // ch0 rising edges, three pulses held 4 cycles each; latency of 2 clocks
    mode = {EDGE_RISE, EDGE_RISE, EDGE_RISE, EDGE_RISE};
    for (int p = 0; p < 3; p++) begin
      din[0] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (p == 0 && j < 3) check($sformatf("latency_step%0d", j), 32'(cnt_bus_s[W-1:0]),
                                   (j == 2) ? 32'd1 : 32'd0);
      end
      din[0] = 1'b0;
      ticks(4);
    end
    check("rise_ch0", 32'(cnt_bus_s[W-1:0]), 32'd3);
    check("rise_others", 32'(cnt_bus_s[NCH*W-1:W]), 32'd0);

    // ch1 FALL, ch2 BOTH, ch3 OFF: five pulses
    clr = 1'b1; tick(); clr = 1'b0;
    mode = {EDGE_OFF, EDGE_BOTH, EDGE_FALL, EDGE_RISE};
    repeat (5) begin
      din[3:1] = 3'b111; ticks(3);
      din[3:1] = 3'b000; ticks(3);
    end
    ticks(2);
    check("fall_ch1", 32'(cnt_bus_s[W*1 +: W]), 32'd5);
    check("both_ch2", 32'(cnt_bus_s[W*2 +: W]), 32'd10);
    check("off_ch3", 32'(cnt_bus_s[W*3 +: W]), 32'd0);

    // Overflow: 2^W+1 rising edges
    clr = 1'b1; tick(); clr = 1'b0;
    mode = '0;
    repeat (MAXV + 2) begin
      din[0] = 1'b1; ticks(2);
      din[0] = 1'b0; ticks(2);
    end
    ticks(2);
    check("sat_hold_max", 32'(cnt_bus_s[W-1:0]), 32'(MAXV));
    check("sat_ovf_set", 32'(ovf_s[0]), 32'd1);
    check("wrap_to_one", 32'(cnt_bus_w[W-1:0]), 32'd1);
    check("wrap_ovf_set", 32'(ovf_w[0]), 32'd1);

    // Read-clear coinciding with a counted edge
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (6) begin
      din[0] = 1'b1; ticks(2);
      din[0] = 1'b0; ticks(2);
    end
    ticks(2);
    check("pre_read_cnt", 32'(cnt_bus_s[W-1:0]), 32'd6);
    din[0] = 1'b1; ticks(2);
    rd_en = 1'b1; rd_sel = 2'd0; tick();
    check("rd_data_6", 32'(rd_data_s), 32'd6);
    check("rd_valid_hi", 32'(rd_valid_s), 32'd1);
    check("cnt_after_rd_edge", 32'(cnt_bus_s[W-1:0]), 32'd1);
    rd_en = 1'b0; din[0] = 1'b0; tick();
    check("rd_valid_lo", 32'(rd_valid_s), 32'd0);
    check("rd_data_hold", 32'(rd_data_s), 32'd6);
    rd_en = 1'b1; tick();
    check("rd_data_1", 32'(rd_data_s), 32'd1);
    tick();
    check("rd_data_0", 32'(rd_data_s), 32'd0);
    rd_en = 1'b0;

    // clr + edge + read of ch2 in the same cycle
    clr = 1'b1; tick(); clr = 1'b0;
    mode = {EDGE_RISE, EDGE_BOTH, EDGE_RISE, EDGE_RISE};
    repeat (2) begin
      din[2] = 1'b1; ticks(2);
      din[2] = 1'b0; ticks(2);
    end
    ticks(2);
    din[2] = 1'b1; ticks(2);
    clr = 1'b1; rd_en = 1'b1; rd_sel = 2'd2; tick();
    check("clr_rd_data", 32'(rd_data_s), 32'd4);
    check("clr_cnt_bus", 32'(cnt_bus_s), 32'd0);
    check("clr_ovf", 32'(ovf_s), 32'd0);
    clr = 1'b0; rd_en = 1'b0; tick();
    check("clr_edge_lost", 32'(cnt_bus_s[W*2 +: W]), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      din    = NCH'($urandom);
      if ($urandom_range(15) == 0) mode = (2*NCH)'($urandom);
      clr    = ($urandom_range(31) == 0);
      rd_en  = ($urandom_range(3) == 0);
      rd_sel = 2'($urandom);
      tick();
    end
    clr = 1'b0; rd_en = 1'b0;

    // Asynchronous reset mid-operation with a pending read, din0 held high
    mode = '0; din = 4'b0001; rd_en = 1'b1; rd_sel = 2'd1;
    ticks(3);
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    check("async_rd_data", 32'(rd_data_s), 32'd0);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rel_rd_valid", 32'(rd_valid_s), 32'd0);
    check_all();
    ticks(4);
    check("reset_artefact_rise", 32'(cnt_bus_s[W-1:0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
